sseg_scan_driver: RTL and testbench

- Consumes the 32-bit display word that top level presents from the stack/queue memory output, along with the memory's empty flag.
- Drives an 8-digit, common-anode, time-multiplexed seven-segment display. It is the reader/display end of the toSSEG path.
- Scans one hex nibble per digit slot.
- Latches a coherent snapshot once per scan frame so pushes and pops never tear the display.

---
 rtl/sseg_scan_driver.sv | 145 ++++++++++++++
 tb/tb_sseg_scan_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
//
// Reader/display end of the toSSEG path. Scans an 8-digit, common-anode,
// time-multiplexed seven-segment display, one hex nibble per digit slot.
// A snapshot of value/empty/dp is taken once per scan frame, on the last slot
// tick before the scan wraps to digit 0, so pushes and pops upstream never
// tear a frame.
//
// Optional build macro:
//   SSEG_LZ_BLANK_EN  defined   -> leading-zero suppression (digit 0 always lit)
//                     undefined -> all eight digits always shown
//
// Parameters:
//   REFRESH_COUNT  clocks per digit slot (>= 2)
//   DIV_W          slot divider width, 2**DIV_W >= REFRESH_COUNT
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-low reset
//   value  in   32-bit word; nibble k on digit k (digit 0 rightmost)
//   empty  in   memory empty flag; shows dashes when latched high
//   dp     in   per-digit decimal-point request, active-high
//   an     out  digit anodes, active-low
//   seg    out  segments {g,f,e,d,c,b,a}, active-low
//   dp_n   out  decimal point, active-low
// -----------------------------------------------------------------------------
module sseg_scan_driver #(
    parameter int REFRESH_COUNT = 100000,
    parameter int DIV_W         = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        empty,
    input  logic [7:0]  dp,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [31:0]      frame_val;
    logic             frame_empty;
    logic [7:0]       frame_dp;
    logic             tick;
    logic             blank;
    logic [3:0]       nib;
    logic [7:0]       an_p0;
    logic [6:0]       seg_p0;
    logic             dp_n_p0;

    assign tick = (div_cnt == DIV_W'(REFRESH_COUNT - 1));
    assign nib  = frame_val[{idx, 2'b00} +: 4];

    // Stage 0: slot divider, digit index and once-per-frame snapshot
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt     <= '0;
            idx         <= '0;
            frame_val   <= '0;
            frame_empty <= 1'b0;
            frame_dp    <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
            // Snapshot on the 7->0 wrap so a whole frame shows one coherent word
            if (idx == 3'd7) begin
                frame_val   <= value;
                frame_empty <= empty;
                frame_dp    <= dp;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

`ifdef SSEG_LZ_BLANK_EN
    // Highest digit holding a nonzero nibble; depends on frame_val only,
    // so the mask is constant for the whole frame.
    logic [2:0] lz_top;
    always_comb begin
        lz_top = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (frame_val[4*k +: 4] != 4'h0) lz_top = 3'(k);
        end
        blank = (idx > lz_top);
    end
`else
    assign blank = 1'b0;
`endif

    // Stage 0 -> output: decode the current slot; empty wins over blanking
    always_comb begin
        an_p0   = ~(8'b1 << idx);
        seg_p0  = hex7(nib);
        dp_n_p0 = ~frame_dp[idx];
        if (frame_empty) begin
            seg_p0  = 7'h3F;
            dp_n_p0 = 1'b1;
        end else if (blank) begin
            an_p0   = 8'hFF;
            seg_p0  = 7'h7F;
            dp_n_p0 = 1'b1;
        end
    end

    // Stage 1: registered display outputs, one clock behind idx
    always_ff @(posedge clk) begin
        if (!rst) begin
            an   <= 8'hFF;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
        end else begin
            an   <= an_p0;
            seg  <= seg_p0;
            dp_n <= dp_n_p0;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_driver
//
// Directed bench for sseg_scan_driver with REFRESH_COUNT=4, DIV_W=3.
// Walks reset, scan order, frame coherence, empty override, leading-zero
// handling (expectations follow SSEG_LZ_BLANK_EN) and a mid-scan reset.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;

    localparam int RC = 4;
`ifdef SSEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        empty;
    logic [7:0]  dp;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    int n_assert = 0;
    int n_fail   = 0;

    sseg_scan_driver #(.REFRESH_COUNT(RC), .DIV_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .empty (empty),
        .dp    (dp),
        .an    (an),
        .seg   (seg),
        .dp_n  (dp_n)
    );

    always #5 clk = ~clk;

    // Segment patterns {g..a}, active-low, indexed by nibble
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg,
                       input logic e_dpn);
        n_assert++;
        assert (an === e_an) else begin
            n_fail++;
            $error("FAIL %s an: observed %h expected %h", tag, an, e_an);
        end
        n_assert++;
        assert (seg === e_seg) else begin
            n_fail++;
            $error("FAIL %s seg: observed %h expected %h", tag, seg, e_seg);
        end
        n_assert++;
        assert (dp_n === e_dpn) else begin
            n_fail++;
            $error("FAIL %s dp_n: observed %b expected %b", tag, dp_n, e_dpn);
        end
    endtask

    // Check ndig full digit slots of a frame holding (fv, fe, fdp). After the
    // first clock of digit chg_d, the inputs are switched to (nv, ne, ndp).
    task automatic frame_chk(input string name, input logic [31:0] fv, input logic fe,
                             input logic [7:0] fdp, input int ndig, input int chg_d,
                             input logic [31:0] nv, input logic ne, input logic [7:0] ndp);
        int top;
        top = 0;
        for (int k = 0; k < 8; k++)
            if (fv[4*k +: 4] != 4'h0) top = k;
        for (int d = 0; d < ndig; d++) begin
            for (int c = 0; c < RC; c++) begin
                logic [7:0] e_an;
                logic [6:0] e_seg;
                logic       e_dpn;
                @(posedge clk);
                #1;
                e_an  = ~(8'b1 << d);
                e_seg = seg_tab[fv[4*d +: 4]];
                e_dpn = ~fdp[d];
                if (fe) begin
                    e_seg = 7'h3F;
                    e_dpn = 1'b1;
                end else if (LZ && d > top) begin
                    e_an  = 8'hFF;
                    e_seg = 7'h7F;
                    e_dpn = 1'b1;
                end
                chk($sformatf("%s d%0d c%0d", name, d, c), e_an, e_seg, e_dpn);
                if (d == chg_d && c == 0) begin
                    value = nv;
                    empty = ne;
                    dp    = ndp;
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b0;
        value = 32'hFFFF_FFFF;
        empty = 1'b0;
        dp    = 8'h00;

        // Reset held for three clocks
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("reset%0d", i), 8'hFF, 7'h7F, 1'b1);
        end
        rst = 1'b1;

        // First edge after release: digit 0 of an all-zero frame
        @(posedge clk);
        #1;
        chk("first_out", 8'hFE, 7'h40, 1'b1);
        value = 32'h1234_5678;
        dp    = 8'h04;

        // Rest of the all-zero first frame
        repeat (8 * RC - 1) @(posedge clk);

        // Scan order of the captured word
        frame_chk("scan", 32'h1234_5678, 1'b0, 8'h04, 8, -1, 32'h0, 1'b0, 8'h00);

        // Change input while idx==3; digits 4..7 must still show the old word
        frame_chk("coher", 32'h1234_5678, 1'b0, 8'h04, 8, 3, 32'hAAAA_AAAA, 1'b0, 8'h04);

        // New word after the wrap; request empty with all dps for next frame
        frame_chk("wrapA", 32'hAAAA_AAAA, 1'b0, 8'h04, 8, 0, 32'hAAAA_AAAA, 1'b1, 8'hFF);

        // Empty override; release empty and load 0xA5 for next frame
        frame_chk("empty", 32'hAAAA_AAAA, 1'b1, 8'hFF, 8, 0, 32'h0000_00A5, 1'b0, 8'h00);

        // Leading zeros of 0xA5
        frame_chk("lzA5", 32'h0000_00A5, 1'b0, 8'h00, 8, 0, 32'h0, 1'b0, 8'h00);

        // All-zero word
        frame_chk("lz0", 32'h0, 1'b0, 8'h00, 8, 0, 32'h1234_5678, 1'b0, 8'h00);

        // Mid-scan reset while idx==5
        frame_chk("pre_rst", 32'h1234_5678, 1'b0, 8'h00, 5, -1, 32'h0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk("idx5", 8'hDF, 7'h30, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst", 8'hFF, 7'h7F, 1'b1);
        rst = 1'b1;
        frame_chk("restart", 32'h0, 1'b0, 8'h00, 2, -1, 32'h1234_5678, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
